// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//
// Drives a 4-digit multiplexed 7-segment display through one shared
// BCD-to-7-segment decoder. A binary value (0..9999) is loaded through a
// one-cycle handshake, converted to four BCD digits by a sequential
// double-dabble engine (one iteration per clock), and committed atomically
// to the display register. An independent scanner walks the four digit
// slots, presenting one nibble to the decoder and asserting the matching
// one-hot digit enable.
//
// Parameters
//   PRESCALE  clock cycles per digit slot (>= 1)
//   LZB       1 = blank leading zeros on digits 3..1, 0 = show all digits
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   value_i  in  14   binary value to display (values above 9999 clamp)
//   load_i   in   1   load request, honoured only while idle
//   busy_o   out  1   conversion in progress; loads are dropped while high
//   ovf_o    out  1   last committed value was clamped to 9999
//   digit_o  out  4   nibble for the decoder; 4'hF is the blank code
//   an_o     out  4   one-hot digit enable, bit 0 = least significant digit
// -----------------------------------------------------------------------------
module seg_scan_controller #(
    parameter int PRESCALE = 1000,
    parameter int LZB      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value_i,
    input  logic        load_i,
    output logic        busy_o,
    output logic        ovf_o,
    output logic [3:0]  digit_o,
    output logic [3:0]  an_o
);

    localparam int          PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PTERM = PW'(PRESCALE - 1);
    localparam logic [13:0] VMAX    = 14'd9999;
    localparam logic [3:0]  ITER_LAST = 4'd13;
    localparam logic [3:0]  BLANK   = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Conversion datapath
    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic        clamp_q;
    logic [3:0]  iter_q;
    logic [29:0] dabble_shift;
    logic        load_accept;

    // Display and scanner
    logic [15:0]   disp_q;
    logic          ovf_q;
    logic [PW-1:0] presc_q;
    logic [1:0]    slot_q;
    logic [3:0]    blank;
    logic [3:0]    slot_digit;

    // Values above the 4-digit range saturate to 9999.
    function automatic logic [13:0] clamp_value(input logic [13:0] v);
        return (v > VMAX) ? VMAX : v;
    endfunction

    // Double-dabble correction: any BCD nibble >= 5 gets +3 so that the
    // following left shift carries correctly into the next decade.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  nib;
        r = b;
        for (int i = 0; i < 4; i++) begin
            nib = b[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            r[4*i +: 4] = nib;
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Conversion FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_accept = 1'b0;
        case (state)
            IDLE: begin
                if (load_i) begin
                    load_accept = 1'b1;
                    state_nxt   = CONVERT;
                end
            end
            CONVERT: begin
                if (iter_q == ITER_LAST) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy_o = (state != IDLE);

    // Iteration counter: cleared on load, counts 0..13 across the 14
    // CONVERT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_q <= '0;
        end else if (load_accept) begin
            iter_q <= '0;
        end else if (state == CONVERT) begin
            iter_q <= iter_q + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Double-dabble shift register: {bcd, bin} moves left one bit per
    // iteration after the nibble correction. The MSB shifted out of the BCD
    // field is always zero because the input never exceeds 9999.
    // -------------------------------------------------------------------------
    assign dabble_shift = {dabble_adjust(bcd_q), bin_q} << 1;

    always_ff @(posedge clk) begin
        if (load_accept) begin
            bin_q   <= clamp_value(value_i);
            bcd_q   <= '0;
            clamp_q <= (value_i > VMAX);
        end else if (state == CONVERT) begin
            bcd_q <= dabble_shift[29:14];
            bin_q <= dabble_shift[13:0];
        end
    end

    // -------------------------------------------------------------------------
    // Display register: only written in COMMIT, all four digits at once, so
    // the scanner never sees a half-converted value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else if (state == COMMIT) begin
            disp_q <= bcd_q;
            ovf_q  <= clamp_q;
        end
    end

    assign ovf_o = ovf_q;

    // -------------------------------------------------------------------------
    // Scanner: free-running, independent of the conversion FSM.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            slot_q  <= '0;
        end else if (presc_q == PTERM) begin
            presc_q <= '0;
            slot_q  <= slot_q + 2'd1;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // A digit is blanked when it and every more significant digit are zero.
    // Digit 0 is never blanked so a zero value still shows "0".
    always_comb begin
        blank    = 4'b0000;
        if (LZB != 0) begin
            blank[3] = (disp_q[15:12] == 4'd0);
            blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
            blank[1] = blank[2] && (disp_q[7:4]  == 4'd0);
        end
    end

    always_comb begin
        slot_digit = disp_q[3:0];
        case (slot_q)
            2'd0: slot_digit = disp_q[3:0];
            2'd1: slot_digit = disp_q[7:4];
            2'd2: slot_digit = disp_q[11:8];
            2'd3: slot_digit = disp_q[15:12];
            default: slot_digit = disp_q[3:0];
        endcase
    end

    // Both outputs decode purely from registers; the enable stays asserted
    // on blanked slots so the decoder renders the blank code there.
    assign digit_o = blank[slot_q] ? BLANK : slot_digit;
    assign an_o    = 4'b0001 << slot_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] value = '0;
    logic        load = 1'b0;

    logic       busy_a, ovf_a, busy_b, ovf_b, busy_c, ovf_c;
    logic [3:0] dig_a, an_a, dig_b, an_b, dig_c, an_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // a: PRESCALE=1 with blanking, b: PRESCALE=1 without, c: PRESCALE=4
    seg_scan_controller #(.PRESCALE(1), .LZB(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load),
        .busy_o(busy_a), .ovf_o(ovf_a), .digit_o(dig_a), .an_o(an_a));
    seg_scan_controller #(.PRESCALE(1), .LZB(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load),
        .busy_o(busy_b), .ovf_o(ovf_b), .digit_o(dig_b), .an_o(an_b));
    seg_scan_controller #(.PRESCALE(4), .LZB(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .value_i(value), .load_i(load),
        .busy_o(busy_c), .ovf_o(ovf_c), .digit_o(dig_c), .an_o(an_c));

    // Reference model: a busy countdown of 15 cycles after an accepted load,
    // committing the clamped value when it expires; scanning is derived from
    // the number of clock edges since reset.
    int m_cnt, m_pval, m_disp, m_cyc;
    bit m_povf, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_disp <= 0; m_ovf <= 1'b0; m_cyc <= 0;
            m_pval <= 0; m_povf <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_cnt == 0) begin
                if (load) begin
                    m_pval <= (int'(value) > 9999) ? 9999 : int'(value);
                    m_povf <= (int'(value) > 9999);
                    m_cnt  <= 15;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_disp <= m_pval;
                    m_ovf  <= m_povf;
                end
            end
        end
    end

    function automatic int pow10(input int k);
        case (k)
            0: return 1;
            1: return 10;
            2: return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic logic [3:0] exp_digit(input int disp, input int slot, input bit lzb);
        if (lzb && slot > 0 && disp < pow10(slot)) return 4'hF;
        return 4'((disp / pow10(slot)) % 10);
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic load_value(input int v);
        value = 14'(v);
        load  = 1'b1;
        cyc();
        load  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (an_a !== 4'b0001 || dig_a !== 4'h0 || busy_a !== 1'b0 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: got an=%b dig=%h busy=%b ovf=%b expected an=0001 dig=0 busy=0 ovf=0",
                     an_a, dig_a, busy_a, ovf_a);
        end
        checks++;
        if (an_c !== 4'b0001 || dig_c !== 4'h0 || busy_c !== 1'b0 || ovf_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_c: got an=%b dig=%h busy=%b ovf=%b expected an=0001 dig=0 busy=0 ovf=0",
                     an_c, dig_c, busy_c, ovf_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_1234();
        logic [3:0] tbl [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        int n = 0;
        int s;
        load_value(1234);
        for (int i = 0; i < 40; i++) begin
            if (busy_a !== 1'b1) break;
            n++;
            cyc();
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL busy_len: got %0d cycles expected 15", n);
        end
        checks++;
        if (ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL ovf_1234: got %b expected 0", ovf_a);
        end
        for (int i = 0; i < 4; i++) begin
            s = m_cyc % 4;
            checks++;
            if (an_a !== 4'(1 << s) || dig_a !== tbl[s]) begin
                errors++;
                $display("FAIL show_1234 slot%0d: got an=%b dig=%h expected an=%b dig=%h",
                         s, an_a, dig_a, 4'(1 << s), tbl[s]);
            end
            cyc();
        end
    endtask

    task automatic test_blanking();
        int vals [3] = '{7, 0, 1002};
        logic [3:0] ea [3][4] = '{'{4'd7, 4'hF, 4'hF, 4'hF},
                                  '{4'd0, 4'hF, 4'hF, 4'hF},
                                  '{4'd2, 4'd0, 4'd0, 4'd1}};
        logic [3:0] eb [3][4] = '{'{4'd7, 4'd0, 4'd0, 4'd0},
                                  '{4'd0, 4'd0, 4'd0, 4'd0},
                                  '{4'd2, 4'd0, 4'd0, 4'd1}};
        int s;
        for (int t = 0; t < 3; t++) begin
            load_value(vals[t]);
            wait_cycles(15);
            for (int i = 0; i < 4; i++) begin
                s = m_cyc % 4;
                checks++;
                if (dig_a !== ea[t][s] || an_a !== 4'(1 << s)) begin
                    errors++;
                    $display("FAIL blank_lzb v=%0d slot%0d: got dig=%h an=%b expected dig=%h an=%b",
                             vals[t], s, dig_a, an_a, ea[t][s], 4'(1 << s));
                end
                checks++;
                if (dig_b !== eb[t][s]) begin
                    errors++;
                    $display("FAIL blank_nolzb v=%0d slot%0d: got %h expected %h",
                             vals[t], s, dig_b, eb[t][s]);
                end
                cyc();
            end
        end
    endtask

    task automatic test_clamp();
        logic [3:0] tbl5 [4] = '{4'd5, 4'hF, 4'hF, 4'hF};
        int s;
        load_value(12000);
        wait_cycles(15);
        checks++;
        if (ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", ovf_a);
        end
        for (int i = 0; i < 4; i++) begin
            s = m_cyc % 4;
            checks++;
            if (dig_a !== 4'd9) begin
                errors++;
                $display("FAIL clamp_digit slot%0d: got %h expected 9", s, dig_a);
            end
            cyc();
        end
        load_value(5);
        wait_cycles(14);
        checks++;
        if (ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: got %b expected 1 before commit", ovf_a);
        end
        cyc();
        checks++;
        if (ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", ovf_a);
        end
        for (int i = 0; i < 4; i++) begin
            s = m_cyc % 4;
            checks++;
            if (dig_a !== tbl5[s]) begin
                errors++;
                $display("FAIL show_5 slot%0d: got %h expected %h", s, dig_a, tbl5[s]);
            end
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] t1 [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        logic [3:0] t2 [4] = '{4'd8, 4'd7, 4'd6, 4'd5};
        int s;
        load_value(1234);            // accepted at E
        wait_cycles(2);
        load_value(5678);            // pulse at E+3, dropped
        wait_cycles(11);             // now just after E+14
        value = 14'd5678;
        load  = 1'b1;
        cyc();                       // E+15: dropped, commit of 1234
        s = m_cyc % 4;
        checks++;
        if (busy_a !== 1'b0 || dig_a !== t1[s]) begin
            errors++;
            $display("FAIL drop_e15 slot%0d: got busy=%b dig=%h expected busy=0 dig=%h",
                     s, busy_a, dig_a, t1[s]);
        end
        cyc();                       // E+16: accepted
        load = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL accept_e16: got busy=%b expected 1", busy_a);
        end
        for (int i = 0; i < 4; i++) begin
            s = m_cyc % 4;
            checks++;
            if (dig_a !== t1[s]) begin
                errors++;
                $display("FAIL hold_1234 slot%0d: got %h expected %h", s, dig_a, t1[s]);
            end
            cyc();
        end
        wait_cycles(11);
        for (int i = 0; i < 4; i++) begin
            s = m_cyc % 4;
            checks++;
            if (dig_a !== t2[s] || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL show_5678 slot%0d: got dig=%h busy=%b expected dig=%h busy=0",
                         s, dig_a, busy_a, t2[s]);
            end
            cyc();
        end
    endtask

    task automatic test_reset_prescale4();
        // Display currently holds 5678; reset mid-cycle must act at once.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an_a !== 4'b0001 || dig_a !== 4'h0 || busy_a !== 1'b0 || ovf_a !== 1'b0 ||
            an_c !== 4'b0001 || dig_c !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: got an_a=%b dig_a=%h busy=%b ovf=%b an_c=%b dig_c=%h expected 0001 0 0 0 0001 0",
                     an_a, dig_a, busy_a, ovf_a, an_c, dig_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (an_c !== 4'(1 << ((i / 4) % 4))) begin
                errors++;
                $display("FAIL p4_scan i=%0d: got %b expected %b", i, an_c, 4'(1 << ((i / 4) % 4)));
            end
            checks++;
            if (an_a !== 4'(1 << (i % 4))) begin
                errors++;
                $display("FAIL p1_scan i=%0d: got %b expected %b", i, an_a, 4'(1 << (i % 4)));
            end
            cyc();
        end
    endtask

    task automatic test_reset_midconv();
        logic [3:0] ta [4] = '{4'd0, 4'hF, 4'hF, 4'hF};
        int s;
        load_value(4321);
        wait_cycles(7);              // just after iteration 7
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b expected 0", busy_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(20);
        for (int i = 0; i < 4; i++) begin
            s = m_cyc % 4;
            checks++;
            if (dig_a !== ta[s] || dig_b !== 4'd0 || busy_a !== 1'b0 || ovf_a !== 1'b0) begin
                errors++;
                $display("FAIL abort_disp slot%0d: got dig_a=%h dig_b=%h busy=%b ovf=%b expected %h 0 0 0",
                         s, dig_a, dig_b, busy_a, ovf_a, ta[s]);
            end
            cyc();
        end
    endtask

    task automatic test_random();
        int sa, sc;
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(99, 0) != 0);
            load  = ($urandom_range(3, 0) == 0);
            value = 14'($urandom_range(16383, 0));
            cyc();
            sa = m_cyc % 4;
            sc = (m_cyc / 4) % 4;
            checks++;
            if (busy_a !== (m_cnt != 0) || busy_b !== (m_cnt != 0) || busy_c !== (m_cnt != 0)) begin
                errors++;
                $display("FAIL rnd_busy i=%0d: got %b%b%b expected %b", i, busy_a, busy_b, busy_c, m_cnt != 0);
            end
            checks++;
            if (ovf_a !== m_ovf || ovf_b !== m_ovf || ovf_c !== m_ovf) begin
                errors++;
                $display("FAIL rnd_ovf i=%0d: got %b%b%b expected %b", i, ovf_a, ovf_b, ovf_c, m_ovf);
            end
            checks++;
            if (an_a !== 4'(1 << sa) || an_b !== 4'(1 << sa) || an_c !== 4'(1 << sc)) begin
                errors++;
                $display("FAIL rnd_an i=%0d: got %b %b %b expected %b %b %b",
                         i, an_a, an_b, an_c, 4'(1 << sa), 4'(1 << sa), 4'(1 << sc));
            end
            checks++;
            if (dig_a !== exp_digit(m_disp, sa, 1'b1) || dig_b !== exp_digit(m_disp, sa, 1'b0) ||
                dig_c !== exp_digit(m_disp, sc, 1'b1)) begin
                errors++;
                $display("FAIL rnd_digit i=%0d disp=%0d: got %h %h %h expected %h %h %h",
                         i, m_disp, dig_a, dig_b, dig_c, exp_digit(m_disp, sa, 1'b1),
                         exp_digit(m_disp, sa, 1'b0), exp_digit(m_disp, sc, 1'b1));
            end
        end
        rst_n = 1'b1;
        load  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_1234();
        test_blanking();
        test_clamp();
        test_back_to_back();
        test_reset_prescale4();
        test_reset_midconv();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
